// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_pkg: shared types, sizes and bus-drive decode for i2c_cmd_master |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package i2c_pkg;

   localparam int I2C_CMD_BITS = 24;
   localparam int I2C_BYTES    = 3;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_BIT   = 3'd2,
      S_ACK   = 3'd3,
      S_STOP  = 3'd4,
      S_DONE  = 3'd5
   } i2c_state_e;

   typedef struct packed {
      logic scl_low;
      logic sda_low;
   } i2c_drive_t;

   // Open-drain pull-down pattern for a given state/phase; msb is the bit on the wire.
   function automatic i2c_drive_t bus_drive(input i2c_state_e st, input logic [1:0] ph,
                                            input logic msb);
      i2c_drive_t d;
      d = '0;
      case (st)
         S_START: begin
            d.sda_low = (ph != Q0);
            d.scl_low = (ph == Q2) || (ph == Q3);
         end
         S_BIT: begin
            d.sda_low = !msb;
            d.scl_low = (ph == Q0) || (ph == Q3);
         end
         S_ACK: begin
            d.scl_low = (ph == Q0) || (ph == Q3);
         end
         S_STOP: begin
            d.sda_low = (ph == Q0) || (ph == Q1);
            d.scl_low = (ph == Q0);
         end
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_quarter_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_quarter_tick: one-cycle tick every DIV_QUARTER clocks.           |
// | I2C_CLK_STRETCH_EN adds a stall input that holds the final count.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2c_quarter_tick #(
   parameter int DIV_QUARTER = 125
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
`ifdef I2C_CLK_STRETCH_EN
   input  logic stall,
`endif
   output logic tick
);

   localparam int             CNT_W    = (DIV_QUARTER > 2) ? $clog2(DIV_QUARTER) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_QUARTER - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             at_last;
   logic             hold;

   always_comb begin
`ifdef I2C_CLK_STRETCH_EN
      hold = stall;
`else
      hold = 1'b0;
`endif
      at_last = (cnt_q == LAST_CNT);
      // The stall only gates the quarter boundary, so synchronizer latency is hidden.
      tick    = at_last && !hold;
      cnt_d   = cnt_q;
      if (clear || tick) begin
         cnt_d = '0;
      end else if (!at_last) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/i2c_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_cmd_master: serializes one 24-bit write command onto SCL/SDA.    |
// | Optional I2C_CLK_STRETCH_EN honours slave clock stretching.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2c_cmd_master
   import i2c_pkg::*;
#(
   parameter int DIV_QUARTER = 125
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [I2C_CMD_BITS-1:0] i2c_data,
   input  logic                    mgo,
   output logic                    mend,
   output logic                    mack,
   inout  wire                     sclk,
   inout  wire                     sdat
);

   i2c_state_e               state_q, state_d;
   logic [1:0]               phase_q, phase_d;
   logic [4:0]               bit_idx_q, bit_idx_d;
   logic [I2C_BYTES*8-1:0]   shift_q, shift_d;
   logic                     ack_ok_q, ack_ok_d;
   logic                     mend_q, mend_d;
   logic                     mack_q, mack_d;
   i2c_drive_t               drv_q, drv_d;
   logic                     tick;
   logic                     div_clear;

`ifdef I2C_CLK_STRETCH_EN
   logic [1:0] scl_sync_q, scl_sync_d;
   logic       stall;

   always_comb begin
      scl_sync_d = {scl_sync_q[0], sclk};
      stall      = !drv_q.scl_low && !scl_sync_q[1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync_q <= 2'b11;
      end else begin
         scl_sync_q <= scl_sync_d;
      end
   end
`endif

   i2c_quarter_tick #(
      .DIV_QUARTER (DIV_QUARTER)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .clear (div_clear),
`ifdef I2C_CLK_STRETCH_EN
      .stall (stall),
`endif
      .tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      ack_ok_d  = ack_ok_q;
      mend_d    = mend_q;
      mack_d    = mack_q;
      div_clear = (state_q == S_IDLE) || (state_q == S_DONE);

      case (state_q)
         S_IDLE: begin
            if (mgo) begin
               shift_d  = i2c_data;
               ack_ok_d = 1'b1;
               phase_d  = Q0;
               state_d  = S_START;
            end
         end
         S_DONE: begin
            if (!mgo) begin
               mend_d  = 1'b0;
               mack_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            if (tick) begin
               phase_d = phase_q + 2'd1;
               if ((state_q == S_ACK) && (phase_q == Q1) && (sdat == 1'b1)) begin
                  ack_ok_d = 1'b0;
               end
               if (phase_q == Q3) begin
                  case (state_q)
                     S_START: begin
                        state_d   = S_BIT;
                        bit_idx_d = 5'(I2C_CMD_BITS - 1);
                     end
                     S_BIT: begin
                        shift_d = shift_q << 1;
                        // Byte boundaries fall on indices 16, 8 and 0.
                        if (bit_idx_q[2:0] == 3'd0) begin
                           state_d = S_ACK;
                        end else begin
                           bit_idx_d = bit_idx_q - 5'd1;
                        end
                     end
                     S_ACK: begin
                        if (!ack_ok_q || (bit_idx_q == 5'd0)) begin
                           state_d = S_STOP;
                        end else begin
                           state_d   = S_BIT;
                           bit_idx_d = bit_idx_q - 5'd1;
                        end
                     end
                     S_STOP: begin
                        state_d = S_DONE;
                        mend_d  = 1'b1;
                        mack_d  = ack_ok_q;
                     end
                     default: state_d = S_IDLE;
                  endcase
               end
            end
         end
      endcase

      // Register the pin drive from next-state so the open-drain outputs are glitch-free.
      drv_d = bus_drive(state_d, phase_d, shift_d[I2C_BYTES*8-1]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         phase_q   <= Q0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         ack_ok_q  <= 1'b0;
         mend_q    <= 1'b0;
         mack_q    <= 1'b0;
         drv_q     <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         ack_ok_q  <= ack_ok_d;
         mend_q    <= mend_d;
         mack_q    <= mack_d;
         drv_q     <= drv_d;
      end
   end

   assign mend = mend_q;
   assign mack = mack_q;
   assign sclk = drv_q.scl_low ? 1'b0 : 1'bz;
   assign sdat = drv_q.sda_low ? 1'b0 : 1'bz;

endmodule
`default_nettype wire
